// File: rtl/t_ff_toggle_arbiter_if.sv
// Purpose : bundles the request, clear and status signals of the toggle-bank arbiter.
// Latency : none; this is wiring only.
// Backpressure: none; requesters hold req/req_idx until they see their gnt bit.
//
// Signals (master = control agents, slave = arbiter):
//   req        NREQ       per-requester toggle request, level
//   req_idx    NREQ*IDXW  bit index per requester, requester r at [r*IDXW +: IDXW]
//   clr        1          synchronous clear of bank and counter
//   gnt        NREQ       one-hot grant pulse
//   err        1          pulse: granted index was out of range
//   q          WIDTH      toggle bank state
//   toggle_cnt CNTW       number of toggles applied
//   busy       1          an eligible request is present this cycle
interface t_ff_toggle_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 16
);
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;
    logic                 clr;
    logic [NREQ-1:0]      gnt;
    logic                 err;
    logic [WIDTH-1:0]     q;
    logic [CNTW-1:0]      toggle_cnt;
    logic                 busy;

    modport master (
        output req, req_idx, clr,
        input  gnt, err, q, toggle_cnt, busy
    );

    modport slave (
        input  req, req_idx, clr,
        output gnt, err, q, toggle_cnt, busy
    );
endinterface

// File: rtl/t_ff_toggle_arbiter.sv
// Purpose : bank of WIDTH toggle flip-flops shared by NREQ requesters via a round-robin arbiter.
// Latency : grant and toggle both land on the edge that samples the request (gnt visible next cycle).
// Backpressure: one toggle per clock; a just-granted requester is masked for a cycle, clr stalls arbitration.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    slave side of t_ff_toggle_arbiter_if (req/req_idx/clr in; gnt/err/q/toggle_cnt/busy out)
module t_ff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    t_ff_toggle_arbiter_if.slave   bus
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // What the arbiter did at the most recent edge. Every edge picks a fresh
    // state; nothing lingers for more than one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [NREQ-1:0]   win_oh_q, win_oh_d;   // one-hot of last winner
    logic              bad_q, bad_d;         // last winner's index was out of range
    logic [PTRW-1:0]   ptr_q, ptr_d;         // round-robin start point
    logic [WIDTH-1:0]  bank_q, bank_d;       // the toggle cells
    logic [CNTW-1:0]   cnt_q, cnt_d;         // applied-toggle counter

    logic [NREQ-1:0]   gnt_w;
    logic [NREQ-1:0]   elig;
    logic              win_found;
    logic [PTRW-1:0]   win_idx;
    logic [IDXW-1:0]   idx_arr [NREQ];
    logic [IDXW-1:0]   sel_idx;
    logic              idx_ok;

    // Unpack the flat index bus so the winner's field can be selected directly.
    for (genvar r = 0; r < NREQ; r++) begin : g_idx
        assign idx_arr[r] = bus.req_idx[r*IDXW +: IDXW];
    end

    // Grant and error are only live in the cycle right after a GRANT edge;
    // win_oh_q/bad_q keep stale values otherwise and are masked here.
    assign gnt_w = (state_q == ST_GRANT) ? win_oh_q : '0;

    // A requester that is seeing its grant is not eligible, which enforces
    // the one-cycle gap between repeated toggles from a held req.
    assign elig = bus.req & ~gnt_w;

    // Round-robin search: start at ptr_q and walk upward modulo NREQ.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!win_found && elig[c]) begin
                win_found = 1'b1;
                win_idx   = PTRW'(c);
            end
        end
    end

    assign sel_idx = idx_arr[win_idx];
    // Unsigned compare: indices at or above WIDTH have no cell behind them.
    assign idx_ok  = (32'(sel_idx) < 32'(WIDTH));

    // ---------------------------------------------------------------
    // FSM process 1: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM process 2: next state. Clear outranks any arbitration.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = ST_IDLE;
        if (bus.clr) begin
            state_d = ST_CLEAR;
        end else if (win_found) begin
            state_d = ST_GRANT;
        end
    end

    // ---------------------------------------------------------------
    // FSM process 3: datapath next values for the chosen action
    // ---------------------------------------------------------------
    always_comb begin
        win_oh_d = win_oh_q;
        bad_d    = bad_q;
        ptr_d    = ptr_q;
        bank_d   = bank_q;
        cnt_d    = cnt_q;
        case (state_d)
            ST_GRANT: begin
                win_oh_d = NREQ'(1) << win_idx;
                bad_d    = !idx_ok;
                ptr_d    = (win_idx == PTRW'(NREQ - 1)) ? '0 : win_idx + PTRW'(1);
                if (idx_ok) begin
                    bank_d = bank_q ^ (WIDTH'(1) << sel_idx);
                    cnt_d  = cnt_q + CNTW'(1);
                end
            end
            ST_CLEAR: begin
                // Pointer is left alone so pending requests resume where they were.
                bank_d = '0;
                cnt_d  = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_oh_q <= '0;
            bad_q    <= 1'b0;
            ptr_q    <= '0;
            bank_q   <= '0;
            cnt_q    <= '0;
        end else begin
            win_oh_q <= win_oh_d;
            bad_q    <= bad_d;
            ptr_q    <= ptr_d;
            bank_q   <= bank_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.gnt        = gnt_w;
    assign bus.err        = (state_q == ST_GRANT) && bad_q;
    assign bus.q          = bank_q;
    assign bus.toggle_cnt = cnt_q;
    assign bus.busy       = |elig;

endmodule
